// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SRAM responder slice.
// Optional range checking is enabled by defining SRAM_RESPONDER_RANGE_CHECK_EN.
package sram_responder_pkg;

  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_DATA_W       = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Access sequencer states: two half-word accesses, then a one-cycle
  // completion state in which the pipeline is released.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } stateT;

  // SRAM 32-bit word index from a byte offset. The two low bits are
  // dropped, so every access is forced to word alignment; bits above 18
  // fall off, which is what makes large offsets wrap.
  function automatic logic [SRAM_ADDR_W-2:0] wordOf(input logic [31:0] offset);
    return offset[SRAM_ADDR_W:2];
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Bundle of the MEM-stage request bus and the external SRAM pins.
// The err signal is present only when SRAM_RESPONDER_RANGE_CHECK_EN is defined.
interface sram_responder_if;
  import sram_responder_pkg::*;

  // Pipeline request side
  logic                   MEM_R_EN;
  logic                   MEM_W_EN;
  logic [31:0]            address;
  logic [31:0]            writeData;
  logic [31:0]            readData;
  logic                   ready;

  // External SRAM side
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [SRAM_DATA_W-1:0] sram_dq_o;
  logic [SRAM_DATA_W-1:0] sram_dq_i;
  logic                   sram_dq_oe;
  logic                   sram_we_n;
  logic                   sram_oe_n;

`ifdef SRAM_RESPONDER_RANGE_CHECK_EN
  logic                   err;
`endif

  // Pipeline plus SRAM device: issues requests and returns read data.
  modport master (
    output MEM_R_EN, MEM_W_EN, address, writeData, sram_dq_i,
    input  readData, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
`ifdef SRAM_RESPONDER_RANGE_CHECK_EN
    , input err
`endif
  );

  // The responder itself.
  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, writeData, sram_dq_i,
    output readData, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
`ifdef SRAM_RESPONDER_RANGE_CHECK_EN
    , output err
`endif
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing one half-word SRAM access.
// last is high on the final cycle of the half access.
module sram_wait_counter #(
  parameter int HALF_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int               CNT_W    = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] countReg;

  // Reload at the start of each half, count down while it runs, park at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= LOAD_VAL;
    end else if (en && (countReg != '0)) begin
      countReg <= countReg - ONE;
    end
  end

  assign last = (countReg == '0);

endmodule

// File: rtl/sram_responder.sv
// MEM-stage data memory responder: one 32-bit request becomes two 16-bit
// SRAM accesses (low half first) while ready holds the pipeline frozen.
// Define SRAM_RESPONDER_RANGE_CHECK_EN to reject out-of-window addresses
// with an err pulse instead of letting them wrap.
import sram_responder_pkg::*;

module sram_responder #(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          HALF_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  sram_responder_if.slave bus
);

  stateT                  stateReg;
  stateT                  stateNext;
  logic                   reqPresent;
  logic                   acceptReq;
  logic                   skipAccess;
  logic                   halfLast;
  logic                   cntLoad;
  logic                   cntEn;
  logic [31:0]            offset;
  logic                   isWriteReg;
  logic [SRAM_ADDR_W-2:0] wordReg;
  logic [31:0]            dataReg;
  logic [31:0]            readDataReg;

  assign reqPresent = bus.MEM_R_EN | bus.MEM_W_EN;
  assign acceptReq  = (stateReg == IDLE) && reqPresent;
  assign offset     = bus.address - BASE_ADDR;

`ifdef SRAM_RESPONDER_RANGE_CHECK_EN
  logic outOfRange;
  logic errFlagReg;

  // Below the base, or past the 2^19-byte window, is rejected.
  assign outOfRange = (bus.address < BASE_ADDR) || (offset[31:19] != '0);
  assign skipAccess = outOfRange;
  assign bus.err    = (stateReg == DONE) && errFlagReg;

  // Remember whether the accepted request was rejected, for the DONE pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      errFlagReg <= 1'b0;
    end else if (acceptReq) begin
      errFlagReg <= outOfRange;
    end
  end
`else
  assign skipAccess = 1'b0;
`endif

  // Half-access timer shared by LO and HI; reloaded on entry to each.
  assign cntLoad = ((stateReg == IDLE) && (stateNext == LO)) ||
                   ((stateReg == LO)   && (stateNext == HI));
  assign cntEn   = (stateReg == LO) || (stateReg == HI);

  sram_wait_counter #(
    .HALF_CYCLES (HALF_CYCLES)
  ) waitCounter (
    .clk  (clk),
    .rst  (rst),
    .load (cntLoad),
    .en   (cntEn),
    .last (halfLast)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic: DONE always returns to IDLE so a held request is
  // not re-accepted in the same cycle the pipeline advances.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (reqPresent) stateNext = skipAccess ? DONE : LO;
      LO:      if (halfLast)   stateNext = HI;
      HI:      if (halfLast)   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request latch and read-data capture on the final cycle of each half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isWriteReg  <= 1'b0;
      wordReg     <= '0;
      dataReg     <= '0;
      readDataReg <= '0;
    end else begin
      if (acceptReq) begin
        // A request with both enables set is treated as a store.
        isWriteReg <= bus.MEM_W_EN;
        wordReg    <= wordOf(offset);
        dataReg    <= bus.writeData;
`ifdef SRAM_RESPONDER_RANGE_CHECK_EN
        if (outOfRange && !bus.MEM_W_EN) begin
          readDataReg <= '0;
        end
`endif
      end
      if ((stateReg == LO) && halfLast && !isWriteReg) begin
        readDataReg[15:0] <= bus.sram_dq_i;
      end
      if ((stateReg == HI) && halfLast && !isWriteReg) begin
        readDataReg[31:16] <= bus.sram_dq_i;
      end
    end
  end

  assign bus.readData = readDataReg;

  // Output decode: ready and the SRAM strobes follow the state directly,
  // so a reset mid-access drops the strobes at once.
  always_comb begin
    bus.ready      = ((stateReg == IDLE) && !reqPresent) || (stateReg == DONE);
    bus.sram_addr  = '0;
    bus.sram_dq_o  = '0;
    bus.sram_dq_oe = 1'b0;
    bus.sram_we_n  = 1'b1;
    bus.sram_oe_n  = 1'b1;
    if ((stateReg == LO) || (stateReg == HI)) begin
      bus.sram_addr = {wordReg, (stateReg == HI)};
      if (isWriteReg) begin
        bus.sram_we_n  = 1'b0;
        bus.sram_dq_oe = 1'b1;
        bus.sram_dq_o  = (stateReg == HI) ? dataReg[31:16] : dataReg[15:0];
      end else begin
        bus.sram_oe_n = 1'b0;
      end
    end
  end

endmodule
